// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the counter-width helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Never returns 0 so a counter declared with it always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Per-cycle datapath on the {acc, q} register pair: shift-add for multiply,
// restoring shift-subtract for divide. Operands are unsigned magnitudes.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] q_init,
  input  logic [WIDTH-1:0] m_init,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] sub;
  logic             ge;

  always_comb begin
    acc_d = acc_q;
    q_d   = q_q;
    m_d   = m_q;
    sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    sh    = {acc_q, q_q[WIDTH-1]};
    ge    = (sh >= {1'b0, m_q});
    // When ge holds the true difference is below m, so the low WIDTH bits suffice.
    sub   = sh[WIDTH-1:0] - m_q;
    if (load) begin
      acc_d = '0;
      q_d   = q_init;
      m_d   = m_init;
    end else if (step) begin
      if (is_div) begin
        acc_d = ge ? sub : sh[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ge};
      end else begin
        acc_d = sum[WIDTH:1];
        q_d   = {sum[0], q_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      q_q   <= '0;
      m_q   <= '0;
    end else begin
      acc_q <= acc_d;
      q_q   <= q_d;
      m_q   <= m_d;
    end
  end

  assign acc = acc_q;
  assign q   = q_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, MTHI/MTLO,
// start/busy/done handshake and pipeline-flush cancel.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               div0_q, div0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               load, step;
  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   q_init, m_init;
  logic [WIDTH-1:0]   it_acc, it_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (is_div_q),
    .q_init (q_init),
    .m_init (m_init),
    .acc    (it_acc),
    .q      (it_q)
  );

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & A[WIDTH-1];
    b_neg     = signed_op & B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    q_init    = op[1] ? a_mag : b_mag;
    m_init    = op[1] ? b_mag : a_mag;

    // Sign correction; MIN / -1 wraps back to MIN with zero remainder.
    prod = {it_acc, it_q};
    if (neg_q_q) prod = -prod;
    quo = neg_q_q ? -it_q : it_q;
    rem = neg_r_q ? -it_acc : it_acc;
    if (div0_q) quo = '1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              load     = 1'b1;
              is_div_d = op[1];
              neg_q_d  = a_neg ^ b_neg;
              neg_r_d  = a_neg;
              div0_d   = op[1] && (B == '0);
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cancel) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  logic        clk, rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] hi, lo;

  int unsigned n_vec, n_err;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request so that it is sampled at the next rising edge (E0).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Full operation: checks latency, busy profile, one-cycle done and results.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic mid_start);
    int n;
    int busy_gaps;
    issue(o, a, b);
    chk({tag, ".busy_e0"}, 64'(busy), 64'd1);
    n = 0; busy_gaps = 0;
    while (!done && n < 40) begin
      if (mid_start && n == 3) begin
        @(negedge clk);
        start = 1'b1; op = 3'b000; A = 32'd5; B = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      n++;
      if (!done && !busy) busy_gaps++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd33);
    chk({tag, ".busy_gaps"}, 64'(busy_gaps), 64'd0);
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    @(posedge clk);
    #1 chk({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  // Start MULTU 7*9 and cancel so that cancel is sampled at edge E<k>.
  task automatic cancel_at(input string tag, input int k);
    int saw_done;
    issue(3'b001, 32'd7, 32'd9);
    for (int i = 1; i < k; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    saw_done = 0;
    if (done) saw_done++;
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done++;
    end
    chk({tag, ".no_done"}, 64'(saw_done), 64'd0);
    chk({tag, ".hi"}, 64'(hi), 64'h1234);
    chk({tag, ".lo"}, 64'(lo), 64'h5678);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'b000; A = '0; B = '0;
    #12;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("mult_min",  3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_negb",  3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("div_minm1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu",      3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu_z",    3'b011, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
    run_op("div_z",     3'b010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    run_op("busy_ign",  3'b001, 32'd7, 32'd9, 32'd0, 32'd63, 1'b1);

    issue(3'b110, 32'hDEAD, 32'hBEEF);
    chk("reserved.busy", 64'(busy), 64'd0);
    chk("reserved.lo", 64'(lo), 64'd63);

    issue(3'b100, 32'h1234, 32'd0);
    chk("mthi.hi", 64'(hi), 64'h1234);
    chk("mthi.busy", 64'(busy), 64'd0);
    issue(3'b101, 32'h5678, 32'd0);
    chk("mtlo.lo", 64'(lo), 64'h5678);
    chk("mtlo.done", 64'(done), 64'd0);

    cancel_at("cancel_e10", 10);
    cancel_at("cancel_fix", 33);

    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'b100; A = 32'hAAAA;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    chk("cancel_start.hi", 64'(hi), 64'h1234);
    chk("cancel_start.busy", 64'(busy), 64'd0);

    issue(3'b010, 32'd1000, 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
    end
    #3 rst = 1'b1;
    #1;
    chk("rst_mid.busy", 64'(busy), 64'd0);
    chk("rst_mid.done", 64'(done), 64'd0);
    chk("rst_mid.hi", 64'(hi), 64'd0);
    chk("rst_mid.lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 3'b001, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, next to the single-cycle ALU in the execute stage.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles using a start/busy/done handshake.
- Also services MTHI/MTLO.
- Generalises the ALU datapath to parametrised WIDTH and adds pipeline-flush cancel.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  issue request, sampled on clk rise
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved (ignored)
A  input  WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO data)
B  input  WIDTH  operand rt (divisor / multiplier)
cancel  input  1  flush from exception/branch logic; aborts an in-flight operation
busy  output  1  operation in flight; stage must stall reads of HI/LO
done  output  1  one-cycle pulse: HI/LO updated on the same edge
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, immediate, legal mid-operation): hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: accepts start.
  - RUN: WIDTH iterations.
  - FIX: sign correction and write-back.
- IDLE, start=1, cancel=0:
  - op MULT/MULTU/DIV/DIVU:
    - latch |A|, |B| (magnitudes for signed ops; raw for unsigned).
    - latch result signs and a divide-by-zero flag.
    - busy=1 from the next edge; go to RUN.
  - op MTHI/MTLO: write A to hi/lo at that edge; no busy, no done; stay IDLE.
  - reserved op: ignored.
- RUN:
  - one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
  - counter counts 0..WIDTH-1; after the WIDTH-th step go to FIX.
- FIX, one cycle:
  - apply signs.
  - on the exit edge: write hi/lo, done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency:
  - start sampled at edge E0; hi/lo and done change at edge E(WIDTH+1), identical for mul and div.
  - busy is high during cycles E0..E(WIDTH+1).
  - a new start is accepted in the cycle done is high.
- Multiply: {hi,lo} = full 2*WIDTH product. Signed product is negated when sign(A) XOR sign(B).
- Divide:
  - lo = quotient, hi = remainder.
  - quotient truncates toward zero.
  - remainder takes the sign of the dividend.
  - signed MIN / -1 gives lo = MIN, hi = 0 (falls out of the magnitude arithmetic; no trap).
  - divide by zero, signed or unsigned: lo = all ones, hi = A; full latency still applies.
- No overflow output; MULT/DIV never trap.
- start while busy: ignored, including MTHI/MTLO. The issuing stage is responsible for stalling.
- cancel:
  - busy=1: return to IDLE at the next edge, busy=0, done stays 0, hi/lo unchanged.
  - cancel coinciding with the FIX exit edge: cancel wins; no write-back, no done.
  - cancel and start in the same IDLE cycle: start ignored, including MTHI/MTLO.
- hi/lo are registered outputs; no combinational path from A/B/op.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding constants (OP_MULT..OP_MTLO).
  - state enum (IDLE, RUN, FIX).
  - counter-width function clog2(WIDTH).
- One sub-module: muldiv_iter.
  - Holds the per-cycle shift-add / shift-subtract datapath on the {acc, q} register pair, selected by a mul/div flag.
  - The top level keeps the FSM, sign handling, HI/LO and the handshake.

Test Plan:
- Unsigned multiply (WIDTH=32): MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> at E33 hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle, busy high E0..E33.
- Signed multiply: MULT A=-3 (0xFFFFFFFD), B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed divide:
  - DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Divide by zero: DIVU A=100, B=0 -> lo=0xFFFFFFFF, hi=0x00000064 at E33.
- Cancel and busy rules:
  - preload hi=0x1234 via MTHI, lo=0x5678 via MTLO.
  - start MULTU 7*9; assert start with MULT during busy -> ignored.
  - cancel at E10 -> busy=0 after E11, no done, hi/lo stay 0x1234/0x5678.
  - a repeat with cancel exactly at the FIX exit edge gives the same result.
- Reset mid-operation: assert rst in the middle of a DIV -> busy, done, hi, lo all 0 immediately, without a clock edge; after release a fresh MULTU 2*3 -> lo=6, hi=0.
